irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Round-robin arbiter that shares the CPU's single I/O read path among N polled
//  ready-flag peripherals (button_poll instances). It presents one memory-mapped
//  vector/status register pair (vector at 0xA00, status at 0xA01) and an irq flag.
//  A CPU read of the vector claims the winning source and pulses that source's ack,
//  clearing its ready flag. The CPU then polls one address instead of N.
// PARAMETERS
//  N_SRC    4   number of requesters, 2..8
//  IDX_W    $clog2(N_SRC)   width of source index (derived, localparam)
// PORTS
//  clk       in   1       system clock
//  rst_n     in   1       asynchronous active-low reset
//  req       in   N_SRC   level ready flags from peripherals' status bit 0
//  sel       in   1       address decode hit for 0xA00/0xA01 (from top-level mux)
//  a0        in   1       register select: 0 = vector, 1 = status
//  rd        in   1       one-cycle read strobe, qualified by sel
//  wr        in   1       one-cycle write strobe, qualified by sel (mask write)
//  din       in   16      CPU write data
//  dout      out  16      read data, combinational from a0 and registered state
//  ack       out  N_SRC   one-hot registered pulse to the claimed peripheral
//  irq       out  1       high while a vector is latched and unclaimed
// BEHAVIOUR
//  Reset: state=IDLE, ptr=N_SRC-1, vec=0, ack=0, irq=0, mask=all ones. Reset
//  mid-claim drops the ack pulse immediately; the peripheral flag stays set.
//  States:
//   IDLE:    if (req & mask) != 0, pick the first set bit searching from ptr+1
//            upward and wrapping modulo N_SRC; latch vec=idx; go to PENDING.
//   PENDING: irq=1. If sel&rd&!a0, go to CLAIM. Else if req[vec] has dropped,
//            go to IDLE with irq=0 and no ack.
//   CLAIM:   ack[vec]=1 for exactly 1 cycle; ptr<=vec; go to GAP.
//   GAP:     1 cycle, so the peripheral flag clears before re-arbitration;
//            go to IDLE.
//  Latency:
//   - req rise to irq: 1 cycle.
//   - vector read to ack: ack high in the cycle after the read edge.
//   - claimed source eligible again no earlier than 3 cycles after the claim.
//  Vector read (a0=0):
//   - PENDING: dout = {1'b1, 15'(vec)}.
//   - Any other state: dout = 16'h0000; a read has no side effect.
//  Status read (a0=1): dout = {state[1:0], 6'b0, 8'(req)}; no side effect.
//  Simultaneous requests: round-robin from ptr+1; the last-served source has the
//  lowest priority.
//  A rd strobe in CLAIM/GAP is ignored. Only one claim per arbitration.
//  A new req during PENDING does not change vec; it is arbitrated after GAP.
//  sel=0: rd and wr ignored; dout value is don't-care (the top mux discards it).
// CONFIGURATION
//  IRQ_MASK_EN defined:
//   - sel&wr&a0 loads mask<=din[N_SRC-1:0] at the clock edge.
//   - Masked sources are never selected.
//   - Masking vec while PENDING returns to IDLE next cycle with no ack.
//   - Status read bits [15:8] become {state, mask[5:0]} (mask truncated if N_SRC>6).
//  IRQ_MASK_EN undefined: mask is constant all ones, wr is ignored, and status
//  bits [13:8] read 0.
// TESTING
//  1 Reset, req=4'b0100 -> irq=1 after 1 clk; vector read -> 16'h8002; ack=4'b0100
//    for 1 clk; irq=0.
//  2 req=4'b1111 held; vector read 4 times -> vec order 0,1,2,3, then wraps to 0
//    (round-robin from reset ptr=3).
//  3 req=4'b0001 rises then falls before any read -> irq drops, no ack, vector
//    read returns 16'h0000.
//  4 Vector read in IDLE and status read in PENDING -> no ack, state unchanged;
//    status read = {2'b01, 6'b0, 8'(req)}.
//  5 rst_n low during CLAIM -> ack=0 asynchronously, state=IDLE, ptr=3; req still
//    high -> re-pended after release.
//  6 IRQ_MASK_EN: write 0x0001 to 0xA01 with req=4'b0011 -> vector 16'h8000 only;
//    source 1 is never acked.

Source files
------------

// File: rtl/irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_arbiter: round-robin arbiter over polled ready flags, exposing one    |
// | vector/status register pair and an irq flag. Option macro: IRQ_MASK_EN.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module irq_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             sel,
  input  logic             a0,
  input  logic             rd,
  input  logic             wr,
  input  logic [15:0]      din,
  output logic [15:0]      dout,
  output logic [N_SRC-1:0] ack,
  output logic             irq
);

  localparam int IDX_W = $clog2(N_SRC);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] CLAIM   = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] vec;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             any;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] elig;
  logic [5:0]       stat_mask;

`ifdef IRQ_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (sel && wr && a0) begin
      mask <= din[N_SRC-1:0];
    end
  end

  assign stat_mask = 6'(mask);

  logic unused_din_hi;
  assign unused_din_hi = ^din[15:N_SRC];
`else
  assign mask      = '1;
  assign stat_mask = 6'b0;

  logic unused_wr_din;
  assign unused_wr_din = ^{wr, din};
`endif

  assign elig = req & mask;
  assign irq  = (state == PENDING);

  // Walk downward so the nearest eligible source after ptr is the one kept.
  always_comb begin
    any  = 1'b0;
    pick = ptr;
    cand = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_SRC);
      if (elig[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= IDX_W'(N_SRC - 1);
      vec   <= '0;
      ack   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            vec   <= pick;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (sel && rd && !a0) begin
            ack   <= N_SRC'(1) << vec;
            state <= CLAIM;
          end else if (!elig[vec]) begin
            state <= IDLE;
          end
        end
        CLAIM: begin
          ptr   <= vec;
          state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reads are side-effect free; only the PENDING vector read claims, above.
  always_comb begin
    dout = 16'h0000;
    if (a0) begin
      dout = {state, stat_mask, 8'(req)};
    end else if (state == PENDING) begin
      dout = {1'b1, 15'(vec)};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// tb_irq_arbiter: table-driven vectors with a scoreboard queue, plus hand
// sequences for asynchronous reset mid-claim and the optional mask.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        sel, a0, rd, wr;
  logic [15:0] din;
  logic [15:0] dout;
  logic [3:0]  ack;
  logic        irq;

`ifdef IRQ_MASK_EN
  localparam logic [15:0] MS = 16'h0F00;
`else
  localparam logic [15:0] MS = 16'h0000;
`endif

  irq_arbiter #(.N_SRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .a0(a0), .rd(rd),
    .wr(wr), .din(din), .dout(dout), .ack(ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    logic [3:0]  req;
    logic        rd;
    logic        a0;
    logic [15:0] dout;
    logic        irq;
    logic [3:0]  ack;
  } vec_t;

  typedef struct {
    logic [15:0] dout;
    logic        irq;
    logic [3:0]  ack;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(bit r, logic [3:0] q, logic rdv, logic a,
                              logic [15:0] d, logic i, logic [3:0] k);
    vecs.push_back('{r, q, rdv, a, d, i, k});
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sel = 1'b0; a0 = 1'b0; rd = 1'b0; wr = 1'b0; din = 16'h0; req = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    sel = 1'b0; a0 = 1'b0; rd = 1'b0; wr = 1'b0; din = 16'h0; req = 4'b0;

    // Single request, claim, then status reads in GAP and IDLE.
    add(1, 4'b0000, 0, 0, 16'h0000,      0, 4'b0000);
    add(0, 4'b0000, 0, 1, MS,            0, 4'b0000);
    add(0, 4'b0100, 0, 0, 16'h0000,      0, 4'b0000);
    add(0, 4'b0100, 1, 0, 16'h8002,      1, 4'b0000);
    add(0, 4'b0100, 0, 0, 16'h0000,      0, 4'b0100);
    add(0, 4'b0000, 0, 1, 16'hC000 | MS, 0, 4'b0000);
    add(0, 4'b0000, 0, 1, MS,            0, 4'b0000);
    // All four held: order 0,1,2,3 then wrap to 0.
    add(1, 4'b1111, 0, 0, 16'h0000, 0, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      add(0, 4'b1111, 1, 0, 16'h8000 | 16'(n % 4), 1, 4'b0000);
      add(0, 4'b1111, 0, 0, 16'h0000, 0, 4'(1 << (n % 4)));
      add(0, 4'b1111, 0, 0, 16'h0000, 0, 4'b0000);
      add(0, 4'b1111, 0, 0, 16'h0000, 0, 4'b0000);
    end
    // Request withdrawn before the read.
    add(1, 4'b0001, 0, 0, 16'h0000, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 16'h8000, 1, 4'b0000);
    add(0, 4'b0000, 1, 0, 16'h0000, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 16'h0000, 0, 4'b0000);
    // Reads without side effects: vector in IDLE, status in PENDING.
    add(1, 4'b0000, 1, 0, 16'h0000,      0, 4'b0000);
    add(0, 4'b0000, 0, 0, 16'h0000,      0, 4'b0000);
    add(0, 4'b0010, 0, 0, 16'h0000,      0, 4'b0000);
    add(0, 4'b0010, 1, 1, 16'h4002 | MS, 1, 4'b0000);
    add(0, 4'b0010, 1, 1, 16'h4002 | MS, 1, 4'b0000);
    add(0, 4'b0010, 0, 0, 16'h8001,      1, 4'b0000);
    // Late request during PENDING does not displace the latched vector.
    add(1, 4'b0100, 0, 0, 16'h0000, 0, 4'b0000);
    add(0, 4'b0101, 0, 0, 16'h8002, 1, 4'b0000);
    add(0, 4'b0101, 1, 0, 16'h8002, 1, 4'b0000);
    add(0, 4'b0101, 0, 0, 16'h0000, 0, 4'b0100);
    add(0, 4'b0001, 0, 0, 16'h0000, 0, 4'b0000);
    add(0, 4'b0001, 0, 0, 16'h0000, 0, 4'b0000);
    add(0, 4'b0001, 1, 0, 16'h8000, 1, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      else begin
        @(posedge clk);
        #1;
      end
      req = vecs[i].req; rd = vecs[i].rd; a0 = vecs[i].a0; sel = 1'b1; wr = 1'b0;
      sb.push_back('{vecs[i].dout, vecs[i].irq, vecs[i].ack, i});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_dout", e.idx), dout, e.dout);
      check($sformatf("v%0d_irq", e.idx), 16'(irq), 16'(e.irq));
      check($sformatf("v%0d_ack", e.idx), 16'(ack), 16'(e.ack));
    end
    rd = 1'b0;

    // Asynchronous reset in CLAIM: ack drops at once, ptr stays at reset value.
    do_reset();
    sel = 1'b1; req = 4'b0100;
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
    check("rst_claim_ack", 16'(ack), 16'h0004);
    #1 rst_n = 1'b0; req = 4'b1100;
    #1;
    check("rst_async_ack", 16'(ack), 16'h0000);
    check("rst_async_irq", 16'(irq), 16'h0000);
    a0 = 1'b1;
    #1;
    check("rst_async_status", dout, 16'h000C | MS);
    @(posedge clk); #1 rst_n = 1'b1; a0 = 1'b0;
    @(negedge clk);
    check("rst_release_irq", 16'(irq), 16'h0000);
    @(negedge clk);
    check("rst_repend_irq", 16'(irq), 16'h0001);
    check("rst_repend_vec", dout, 16'h8002);

`ifdef IRQ_MASK_EN
    // Mask out source 1: only source 0 is ever served.
    do_reset();
    sel = 1'b1; req = 4'b0011; a0 = 1'b1; wr = 1'b1; din = 16'h0001;
    @(posedge clk); #1 wr = 1'b0; a0 = 1'b0;
    @(negedge clk);
    check("mask_vec0", dout, 16'h8000);
    #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
    check("mask_ack0", 16'(ack), 16'h0001);
    @(posedge clk); #1 req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("mask_idle_irq%0d", c), 16'(irq), 16'h0000);
      check($sformatf("mask_idle_ack%0d", c), 16'(ack), 16'h0000);
      check($sformatf("mask_idle_vec%0d", c), dout, 16'h0000);
      @(posedge clk); #1;
    end
    a0 = 1'b1;
    #1;
    check("mask_status", dout, 16'h0102);
    // Unmask source 1, let it pend, then mask it again while PENDING.
    wr = 1'b1; din = 16'h0003;
    @(posedge clk); #1 wr = 1'b0; a0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mask_pend1", dout, 16'h8001);
    #1 a0 = 1'b1; wr = 1'b1; din = 16'h0001;
    @(posedge clk); #1 wr = 1'b0; a0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mask_drop_irq", 16'(irq), 16'h0000);
    check("mask_drop_ack", 16'(ack), 16'h0000);
    @(negedge clk);
    check("mask_drop_ack2", 16'(ack), 16'h0000);
    check("mask_drop_irq2", 16'(irq), 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
